// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the multiplexed seven-segment display path.
package sevenseg_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam bcd_t       BCD_BLANK = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// Control/data bundle between a display client and sevenseg_scan_ctrl.
interface sevenseg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;
  logic                    load_pending;

  modport master (
    output en, load, digits_in,
    input  seg, an, frame_start, load_pending
  );

  modport slave (
    input  en, load, digits_in,
    output seg, an, frame_start, load_pending
  );
endinterface

// File: rtl/sevenseg_scan_ctrl_sevensegdec.sv
// BCD to seven-segment decoder, segments {a,b,c,d,e,f,g} active-high; non-BCD codes blank.
module sevensegdec
  import sevenseg_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);
  always_comb begin
    unique case (bcd)
      4'h0:    seg = 7'b1111110;
      4'h1:    seg = 7'b0110000;
      4'h2:    seg = 7'b1101101;
      4'h3:    seg = 7'b1111001;
      4'h4:    seg = 7'b0110011;
      4'h5:    seg = 7'b1011011;
      4'h6:    seg = 7'b1011111;
      4'h7:    seg = 7'b1110000;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1111011;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller sharing one sevensegdec across NUM_DIGITS digits.
// Optional leading-zero suppression when SEVENSEG_LZ_BLANK_EN is defined.
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 1000,
  parameter int DEAD_CYCLES = 16
) (
  input logic clk,
  input logic rst_n,
  sevenseg_scan_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);

  scan_state_t state_q, state_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [IDX_W-1:0] idx_q, idx_nxt;
  bcd_t [NUM_DIGITS-1:0] committed_q, committed_nxt, pending_q, pending_nxt;
  logic pending_valid_q, pending_valid_nxt;
  logic frame_start_nxt, on_nxt;
  logic [NUM_DIGITS-1:0] blank_nxt;
  logic [6:0] dec_seg, seg_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic frame_start_q;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt       = IDLE;
    cnt_nxt         = '0;
    idx_nxt         = '0;
    frame_start_nxt = 1'b0;
    if (bus.en) begin
      state_nxt = SCAN;
      if (state_q == IDLE) begin
        frame_start_nxt = 1'b1;
      end else begin
        if (cnt_q == CNT_LAST) begin
          idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
          idx_nxt = idx_q;
        end
        frame_start_nxt = (cnt_nxt == '0) && (idx_nxt == '0);
      end
    end
  end

  // A load coinciding with a commit bypasses the pending register.
  always_comb begin
    committed_nxt     = committed_q;
    pending_nxt       = pending_q;
    pending_valid_nxt = pending_valid_q;
    if (frame_start_nxt) begin
      if (bus.load)             committed_nxt = bus.digits_in;
      else if (pending_valid_q) committed_nxt = pending_q;
      pending_valid_nxt = 1'b0;
    end else if (bus.load) begin
      pending_nxt       = bus.digits_in;
      pending_valid_nxt = 1'b1;
    end
  end

`ifdef SEVENSEG_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] blank_q;

  // Blank mask is frozen at commit so it tracks the committed frame value.
  always_comb begin
    logic lead;
    lead      = 1'b1;
    blank_nxt = blank_q;
    if (frame_start_nxt) begin
      blank_nxt = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        if (lead && committed_nxt[i] == 4'h0) blank_nxt[i] = 1'b1;
        else                                  lead = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= '0;
    else        blank_q <= blank_nxt;
  end
`else
  assign blank_nxt = '0;
`endif

  // Decode the next cycle's digit so seg/an are registered without an extra cycle of lag.
  sevensegdec u_dec (
    .bcd (committed_nxt[idx_nxt]),
    .seg (dec_seg)
  );

  assign on_nxt = (state_nxt == SCAN) && (cnt_nxt >= CNT_DEAD) && !blank_nxt[idx_nxt];

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      idx_q           <= '0;
      committed_q     <= {NUM_DIGITS{BCD_BLANK}};
      pending_q       <= {NUM_DIGITS{BCD_BLANK}};
      pending_valid_q <= 1'b0;
      seg_q           <= SEG_BLANK;
      an_q            <= '0;
      frame_start_q   <= 1'b0;
    end else begin
      state_q         <= state_nxt;
      cnt_q           <= cnt_nxt;
      idx_q           <= idx_nxt;
      committed_q     <= committed_nxt;
      pending_q       <= pending_nxt;
      pending_valid_q <= pending_valid_nxt;
      seg_q           <= on_nxt ? dec_seg : SEG_BLANK;
      an_q            <= on_nxt ? (NUM_DIGITS'(1) << idx_nxt) : '0;
      frame_start_q   <= frame_start_nxt;
    end
  end

  assign bus.seg          = seg_q;
  assign bus.an           = an_q;
  assign bus.frame_start  = frame_start_q;
  assign bus.load_pending = pending_valid_q;

endmodule
